// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x majority-vote sampling, error pulses and a FWFT receive FIFO.
// Optional parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo #(
    parameter int SYSCLK_FREQ = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16,
    parameter int PARITY_ODD  = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          uart_rx,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun_err,
    output logic                          parity_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [31:0]   INC       = 32'(OVERSAMPLE * BAUD_RATE);
    localparam logic [31:0]   FREQ      = 32'(SYSCLK_FREQ);
    localparam logic [CW-1:0] MID_IDX   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] LAST_IDX  = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state;
    logic                 sync1, rx_s, rx_prev;
    logic [31:0]          acc, sum;
    logic                 tick;
    logic [CW-1:0]        cnt;
    logic [1:0]           hist;
    logic                 maj, mid, start_edge;
    logic [3:0]           bit_idx;
    logic                 stop_idx, stop_bad, stop_fail;
    logic [DATA_BITS-1:0] shift;
    logic                 parity_ok, frame_done, push, pop, full;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= uart_rx;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    assign start_edge = (state == IDLE) && rx_prev && !rx_s;
    assign sum        = acc + INC;

    // Fractional baud generator; restarting it on the start edge keeps sample phase locked to the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (start_edge) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (sum >= FREQ) begin
            acc  <= sum - FREQ;
            tick <= 1'b1;
        end else begin
            acc  <= sum;
            tick <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            hist <= 2'b11;
        end else if (start_edge) begin
            cnt <= '0;
        end else if (tick) begin
            hist <= {hist[0], rx_s};
            cnt  <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
        end
    end

    // hist holds the two earlier window samples; the live sample completes the vote.
    assign maj = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
    assign mid = tick && (cnt == MID_IDX);

    assign full       = (fifo_count == (AW + 1)'(FIFO_DEPTH));
    assign rd_valid   = (fifo_count != '0);
    assign pop        = rd_valid && rd_ready;
    assign frame_done = (state == STOP) && mid && (stop_idx == LAST_STOP);
    assign stop_fail  = stop_bad | ~maj;
    assign push       = frame_done && !stop_fail && parity_ok && (!full || pop);

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    assign parity_ok = (((^shift) ^ par_bit) == (PARITY_ODD != 0));
`else
    assign parity_ok  = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            stop_bad    <= 1'b0;
            shift       <= '0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit     <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            frame_err   <= frame_done && stop_fail;
            overrun_err <= frame_done && !stop_fail && parity_ok && full && !pop;
`ifdef UART_RX_PARITY_EN
            parity_err  <= frame_done && !stop_fail && !parity_ok;
`endif
            case (state)
                IDLE: begin
                    if (start_edge) state <= START;
                end
                START: begin
                    if (mid) begin
                        if (maj) begin
                            state <= IDLE;
                        end else begin
                            state    <= DATA;
                            bit_idx  <= '0;
                            stop_idx <= 1'b0;
                            stop_bad <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (mid) begin
                        shift <= {maj, shift[DATA_BITS-1:1]};
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (mid) begin
                        par_bit <= maj;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (mid) begin
                        if (stop_idx == LAST_STOP) begin
                            state <= IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                            stop_bad <= stop_bad | ~maj;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule
